// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: EX operand forwarding, load-use stalls, data-memory freezes.
// Optional HAZARD_PERF_CNT_EN macro builds saturating stall/freeze performance counters.
module hazard_forward_ctrl #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 255,
  parameter int unsigned WAIT_CNT_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_rs1_i,
  input  logic [4:0]  ID_rs2_i,
  input  logic        ID_use_rs2_i,
  input  logic [4:0]  EX_rs1_i,
  input  logic [4:0]  EX_rs2_i,
  input  logic [4:0]  EX_rd_i,
  input  logic        EX_MemRead_i,
  input  logic        EX_RegWrite_i,
  input  logic [4:0]  MEM_rd_i,
  input  logic        MEM_RegWrite_i,
  input  logic [4:0]  WB_rd_i,
  input  logic        WB_RegWrite_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic [1:0]  ForwardA_o,
  output logic [1:0]  ForwardB_o,
  output logic        PCWrite_o,
  output logic        IFID_Write_o,
  output logic        IDEX_Flush_o,
  output logic        freeze_o,
  output logic        timeout_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_freeze_o
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StError   = 2'd2;

  localparam logic [3:0]            LuInit    = 4'(LOAD_USE_CYCLES - 1);
  localparam bit                    LuMulti   = (LOAD_USE_CYCLES > 1);
  localparam bit                    TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_CNT_W-1:0] WaitLast  = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            lu_cnt_q, lu_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  lu_haz, mwait, stall, frz;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_we,
                                         input logic [4:0] mem_rd, input logic wb_we,
                                         input logic [4:0] wb_rd);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return 2'b10;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))    return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    ForwardA_o = 2'b00;
    ForwardB_o = 2'b00;
    if (!rst_i) begin
      ForwardA_o = fwd_sel(EX_rs1_i, MEM_RegWrite_i, MEM_rd_i, WB_RegWrite_i, WB_rd_i);
      ForwardB_o = fwd_sel(EX_rs2_i, MEM_RegWrite_i, MEM_rd_i, WB_RegWrite_i, WB_rd_i);
    end
  end

  assign lu_haz = EX_MemRead_i && EX_RegWrite_i && (EX_rd_i != 5'd0) &&
                  ((EX_rd_i == ID_rs1_i) || (ID_use_rs2_i && (EX_rd_i == ID_rs2_i)));
  assign mwait  = mem_req_i && !mem_ready_i;

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    stall    = 1'b0;
    frz      = 1'b0;
    case (state_q)
      StRun: begin
        if (mwait) begin
          frz = 1'b1;
        end else if (lu_haz) begin
          stall    = 1'b1;
          lu_cnt_d = LuInit;
          if (LuMulti) state_d = StLuStall;
        end
      end
      StLuStall: begin
        if (mwait) begin
          frz = 1'b1;
        end else begin
          stall    = 1'b1;
          lu_cnt_d = lu_cnt_q - 4'd1;
          if (lu_cnt_q == 4'd1) state_d = StRun;
        end
      end
      StError: frz = 1'b1;
      default: state_d = StRun;
    endcase
    // Counter value equals the number of freeze cycles already spent in this wait.
    if (TimeoutEn && mwait && (state_q != StError) && (wait_cnt_q == WaitLast)) begin
      state_d = StError;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (mwait) wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      lu_cnt_q   <= 4'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    PCWrite_o    = 1'b1;
    IFID_Write_o = 1'b1;
    IDEX_Flush_o = 1'b0;
    freeze_o     = 1'b0;
    if (!rst_i) begin
      PCWrite_o    = !(stall || frz);
      IFID_Write_o = !(stall || frz);
      IDEX_Flush_o = stall;
      freeze_o     = frz;
    end
  end

  assign timeout_o = (state_q == StError);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_freeze_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q  <= 32'd0;
      perf_freeze_q <= 32'd0;
    end else begin
      if (IDEX_Flush_o && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (freeze_o && (perf_freeze_q != 32'hFFFF_FFFF)) perf_freeze_q <= perf_freeze_q + 32'd1;
    end
  end

  assign perf_stall_o  = perf_stall_q;
  assign perf_freeze_o = perf_freeze_q;
`else
  assign perf_stall_o  = 32'd0;
  assign perf_freeze_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized bench for hazard_forward_ctrl: two instances (1- and 3-cycle load-use stalls)
// checked every cycle against a stall-budget reference model.
module tb_hazard_forward_ctrl;

  localparam int unsigned Timeout = 8;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs2, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
  logic mem_req, mem_ready;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        pcw [2];
  logic        ifid [2];
  logic        flush [2];
  logic        frz [2];
  logic        tmo [2];
  logic [31:0] pstall [2];
  logic [31:0] pfrz [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: remaining stall cycles, length of current memory wait.
  int lu_len [2] = '{1, 3};
  int stall_rem [2];
  int wait_run [2];
  bit dead [2];
  int perf_s [2];
  int perf_f [2];

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT(Timeout), .WAIT_CNT_W(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .ID_use_rs2_i(id_use_rs2),
    .EX_rs1_i(ex_rs1), .EX_rs2_i(ex_rs2), .EX_rd_i(ex_rd),
    .EX_MemRead_i(ex_mem_read), .EX_RegWrite_i(ex_reg_write),
    .MEM_rd_i(mem_rd), .MEM_RegWrite_i(mem_reg_write),
    .WB_rd_i(wb_rd), .WB_RegWrite_i(wb_reg_write),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .ForwardA_o(fa[0]), .ForwardB_o(fb[0]), .PCWrite_o(pcw[0]), .IFID_Write_o(ifid[0]),
    .IDEX_Flush_o(flush[0]), .freeze_o(frz[0]), .timeout_o(tmo[0]),
    .perf_stall_o(pstall[0]), .perf_freeze_o(pfrz[0])
  );

  hazard_forward_ctrl #(.LOAD_USE_CYCLES(3), .MEM_TIMEOUT(Timeout), .WAIT_CNT_W(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .ID_use_rs2_i(id_use_rs2),
    .EX_rs1_i(ex_rs1), .EX_rs2_i(ex_rs2), .EX_rd_i(ex_rd),
    .EX_MemRead_i(ex_mem_read), .EX_RegWrite_i(ex_reg_write),
    .MEM_rd_i(mem_rd), .MEM_RegWrite_i(mem_reg_write),
    .WB_rd_i(wb_rd), .WB_RegWrite_i(wb_reg_write),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .ForwardA_o(fa[1]), .ForwardB_o(fb[1]), .PCWrite_o(pcw[1]), .IFID_Write_o(ifid[1]),
    .IDEX_Flush_o(flush[1]), .freeze_o(frz[1]), .timeout_o(tmo[1]),
    .perf_stall_o(pstall[1]), .perf_freeze_o(pfrz[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_mem_read = 0; ex_reg_write = 0; mem_rd = 0; mem_reg_write = 0;
    wb_rd = 0; wb_reg_write = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Check both instances for the current inputs, then advance the model past the next edge.
  task automatic step();
    bit mw, lu;
    int kind;  // 0 pass, 1 stall, 2 freeze
    logic [1:0] ea, eb;
    #1;
    mw = mem_req && !mem_ready;
    lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
         (ex_rd == id_rs1 || (id_use_rs2 && ex_rd == id_rs2));
    ea = rst ? 2'b00 : exp_fwd(ex_rs1);
    eb = rst ? 2'b00 : exp_fwd(ex_rs2);
    for (int i = 0; i < 2; i++) begin
      kind = 0;
      if (!rst) begin
        if (dead[i] || mw) kind = 2;
        else if (stall_rem[i] > 0 || lu) kind = 1;
      end
      check($sformatf("fwd_a[%0d]", i), 32'(fa[i]), 32'(ea));
      check($sformatf("fwd_b[%0d]", i), 32'(fb[i]), 32'(eb));
      check($sformatf("pc_write[%0d]", i), 32'(pcw[i]), 32'(kind == 0));
      check($sformatf("ifid_write[%0d]", i), 32'(ifid[i]), 32'(kind == 0));
      check($sformatf("flush[%0d]", i), 32'(flush[i]), 32'(kind == 1));
      check($sformatf("freeze[%0d]", i), 32'(frz[i]), 32'(kind == 2));
      check($sformatf("timeout[%0d]", i), 32'(tmo[i]), 32'(!rst && dead[i]));
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("perf_stall[%0d]", i), pstall[i], rst ? 32'd0 : 32'(perf_s[i]));
      check($sformatf("perf_freeze[%0d]", i), pfrz[i], rst ? 32'd0 : 32'(perf_f[i]));
`else
      check($sformatf("perf_stall[%0d]", i), pstall[i], 32'd0);
      check($sformatf("perf_freeze[%0d]", i), pfrz[i], 32'd0);
`endif
      if (rst) begin
        stall_rem[i] = 0; wait_run[i] = 0; dead[i] = 0; perf_s[i] = 0; perf_f[i] = 0;
      end else begin
        if (kind == 1) begin
          if (stall_rem[i] > 0) stall_rem[i]--;
          else stall_rem[i] = lu_len[i] - 1;
          perf_s[i]++;
        end
        if (kind == 2) perf_f[i]++;
        if (!dead[i] && mw && wait_run[i] == int'(Timeout) - 1) dead[i] = 1;
        wait_run[i] = mw ? ((wait_run[i] < 255) ? wait_run[i] + 1 : 255) : 0;
      end
    end
  endtask

  initial begin
    int burst;
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall_rem[i] = 0; wait_run[i] = 0; dead[i] = 0; perf_s[i] = 0; perf_f[i] = 0;
    end
    #2;
    step();
    check("reset_pc_write", 32'(pcw[1]), 32'd1);
    next(); step();
    next(); rst = 1'b0; step();

    // Forwarding priority and x0 suppression.
    next(); ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1; step();
    check("tp_fwd_mem", 32'(fa[0]), 32'd2);
    next(); mem_reg_write = 0; step();
    check("tp_fwd_wb", 32'(fa[0]), 32'd1);
    next(); mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; step();
    check("tp_fwd_x0", 32'(fa[0]), 32'd0);

    // Single load-use hazard through rs2.
    next(); idle(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    id_rs1 = 3; step();
    check("tp_lu1_flush", 32'(flush[0]), 32'd1);
    check("tp_lu1_pcw", 32'(pcw[0]), 32'd0);
    next(); idle(); step();
    check("tp_lu1_done", 32'(flush[0]), 32'd0);
    check("tp_lu3_cont", 32'(flush[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin next(); step(); end
    next(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
    id_rs1 = 3; step();
    check("tp_no_rs2_use", 32'(flush[0]), 32'd0);

    // 3-cycle stall interrupted by a 4-cycle memory wait.
    next(); idle(); step();
    next(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9; id_rs1 = 9; step();
    next(); idle(); step();
    for (int k = 0; k < 4; k++) begin
      next(); mem_req = 1; mem_ready = 0; step();
      check("tp_frz_noflush", 32'(flush[1]), 32'd0);
    end
    next(); idle(); step();
    check("tp_stall_resume", 32'(flush[1]), 32'd1);
    next(); step();
    check("tp_stall_end", 32'(flush[1]), 32'd0);

    // Memory timeout and recovery by reset.
    for (int k = 0; k < 10; k++) begin
      next(); mem_req = 1; mem_ready = 0; step();
      if (k == 7) check("tp_tmo_pre", 32'(tmo[0]), 32'd0);
      if (k == 8) check("tp_tmo_rise", 32'(tmo[0]), 32'd1);
    end
    next(); idle(); step();
    check("tp_err_freeze", 32'(frz[1]), 32'd1);
    next(); rst = 1; step();
    next(); rst = 0; step();
    check("tp_tmo_clear", 32'(tmo[1]), 32'd0);

    // Random traffic with occasional long memory waits and resets.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      next();
      rst = ($urandom_range(0, 59) == 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_use_rs2 = 1'($urandom); ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      if (burst == 0 && $urandom_range(0, 79) == 0) burst = $urandom_range(3, 12);
      if (burst > 0) begin
        mem_req = 1; mem_ready = 0; burst--;
      end else begin
        mem_req = ($urandom_range(0, 9) < 3); mem_ready = 1'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
